// File: rtl/voltage_monitor_pkg.sv
// -----------------------------------------------------------------------------
// voltage_monitor_pkg
// Shared types for the voltage monitor: the per-channel supervision state and
// the kind of fault that caused entry into FAULT.
// -----------------------------------------------------------------------------
package voltage_monitor_pkg;

    // Per-channel supervision state. FAULT and RECOVER both report a live fault.
    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_PEND    = 2'd1,
        ST_FAULT   = 2'd2,
        ST_RECOVER = 2'd3
    } ch_state_e;

    // Direction of the excursion that pushed a channel into FAULT.
    typedef enum logic {
        FT_UNDER = 1'b0,
        FT_OVER  = 1'b1
    } fault_type_e;

endpackage : voltage_monitor_pkg

// File: rtl/vm_channel.sv
// -----------------------------------------------------------------------------
// vm_channel
// One monitored channel: classifies each addressed sample as out-of-range or
// good, and runs the OK/PEND/FAULT/RECOVER debounce FSM with a persistence
// counter.
//
// Ports
//   clk, reset_n   : clock (rising edge), asynchronous active-low reset
//   sample_en      : a sample for this channel is present this cycle
//   sample_data    : unsigned ADC sample
//   fault          : channel is in FAULT or RECOVER (decoded from state flops)
//   enter          : this cycle's sample moves the channel into FAULT
//   enter_type     : OVER if that sample is above V_MAX, else UNDER
// -----------------------------------------------------------------------------
module vm_channel
    import voltage_monitor_pkg::*;
#(
    parameter int ADC_W   = 12,
    parameter int V_MIN   = 1000,
    parameter int V_MAX   = 3000,
    parameter int HYST    = 100,
    parameter int PERSIST = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic [ADC_W-1:0] sample_data,
    output logic             fault,
    output logic             enter,
    output fault_type_e      enter_type
);

    localparam int CNT_W = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Thresholds folded to ADC_W bits so every comparison is unsigned.
    localparam logic [ADC_W-1:0] OUT_LO  = ADC_W'(V_MIN);
    localparam logic [ADC_W-1:0] OUT_HI  = ADC_W'(V_MAX);
    localparam logic [ADC_W-1:0] GOOD_LO = ADC_W'(V_MIN + HYST);
    localparam logic [ADC_W-1:0] GOOD_HI = ADC_W'(V_MAX - HYST);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             is_out;
    logic             is_good;
    logic             is_over;
    logic [CNT_W-1:0] count_inc;

    assign is_over   = (sample_data > OUT_HI);
    assign is_out    = (sample_data < OUT_LO) || is_over;
    assign is_good   = (sample_data >= GOOD_LO) && (sample_data <= GOOD_HI);
    assign count_inc = count_q + CNT_ONE;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        enter      = 1'b0;
        enter_type = is_over ? FT_OVER : FT_UNDER;

        if (sample_en) begin
            unique case (state_q)
                ST_OK: begin
                    if (is_out) begin
                        if (PERSIST == 1) begin
                            state_d = ST_FAULT;
                            count_d = '0;
                            enter   = 1'b1;
                        end else begin
                            state_d = ST_PEND;
                            count_d = CNT_ONE;
                        end
                    end
                end
                ST_PEND: begin
                    if (!is_out) begin
                        state_d = ST_OK;
                        count_d = '0;
                    end else if (count_inc == CNT_LAST) begin
                        state_d = ST_FAULT;
                        count_d = '0;
                        enter   = 1'b1;
                    end else begin
                        count_d = count_inc;
                    end
                end
                ST_FAULT: begin
                    if (is_good) begin
                        if (PERSIST == 1) begin
                            state_d = ST_OK;
                            count_d = '0;
                        end else begin
                            state_d = ST_RECOVER;
                            count_d = CNT_ONE;
                        end
                    end
                end
                ST_RECOVER: begin
                    // Falling back to FAULT is not a new entry: no enter pulse.
                    if (!is_good) begin
                        state_d = ST_FAULT;
                        count_d = '0;
                    end else if (count_inc == CNT_LAST) begin
                        state_d = ST_OK;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                    end
                end
                default: begin
                    state_d = ST_OK;
                    count_d = '0;
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, matching real hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OK;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign fault = (state_q == ST_FAULT) || (state_q == ST_RECOVER);

endmodule : vm_channel

// File: rtl/voltage_monitor.sv
// -----------------------------------------------------------------------------
// voltage_monitor
// Multi-channel voltage supervisor. Each channel is debounced by a vm_channel
// instance; this level adds sticky fault bits, a one-cycle irq on every new
// fault entry and a first-fault record.
//
// Ports
//   clk, reset_n          : clock (rising edge), asynchronous active-low reset
//   sample_valid          : sample strobe
//   sample_ch             : channel index of the sample
//   sample_data           : unsigned sample value
//   clr_mask              : per-channel sticky-clear pulse
//   fault_vec             : live per-channel fault (FAULT or RECOVER)
//   fault_sticky          : latched per-channel fault
//   fault_any             : OR of fault_vec
//   irq                   : one-cycle pulse on any new fault entry
//   first_valid/ch/over   : first-fault record (over=1 over-voltage)
// -----------------------------------------------------------------------------
module voltage_monitor
    import voltage_monitor_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ADC_W   = 12,
    parameter int V_MIN   = 1000,
    parameter int V_MAX   = 3000,
    parameter int HYST    = 100,
    parameter int PERSIST = 3,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_valid,
    input  logic [CH_W-1:0]  sample_ch,
    input  logic [ADC_W-1:0] sample_data,
    input  logic [N_CH-1:0]  clr_mask,
    output logic [N_CH-1:0]  fault_vec,
    output logic [N_CH-1:0]  fault_sticky,
    output logic             fault_any,
    output logic             irq,
    output logic             first_valid,
    output logic [CH_W-1:0]  first_ch,
    output logic             first_over
);

    logic [N_CH-1:0] enter_vec;
    fault_type_e     enter_type [N_CH];

    // Out-of-range indices never match any channel, so they are ignored.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        vm_channel #(
            .ADC_W   (ADC_W),
            .V_MIN   (V_MIN),
            .V_MAX   (V_MAX),
            .HYST    (HYST),
            .PERSIST (PERSIST)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .sample_en   (sample_valid && (sample_ch == CH_W'(i))),
            .sample_data (sample_data),
            .fault       (fault_vec[i]),
            .enter       (enter_vec[i]),
            .enter_type  (enter_type[i])
        );
    end

    assign fault_any = |fault_vec;

    logic [N_CH-1:0] sticky_q, sticky_d;
    logic            irq_q, irq_d;
    logic            first_valid_q, first_valid_d;
    logic [CH_W-1:0] first_ch_q, first_ch_d;
    logic            first_over_q, first_over_d;

    always_comb begin
        // A set in the same cycle as a clear wins.
        sticky_d      = (sticky_q & ~clr_mask) | enter_vec;
        irq_d         = |enter_vec;
        first_valid_d = first_valid_q;
        first_ch_d    = first_ch_q;
        first_over_d  = first_over_q;

        if (!first_valid_q) begin
            // Only one channel can enter per cycle; the loop just selects it.
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (enter_vec[i]) begin
                    first_valid_d = 1'b1;
                    first_ch_d    = CH_W'(i);
                    first_over_d  = (enter_type[i] == FT_OVER);
                end
            end
        end else if (clr_mask[first_ch_q] && !enter_vec[first_ch_q]) begin
            first_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q      <= '0;
            irq_q         <= 1'b0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            first_over_q  <= 1'b0;
        end else begin
            sticky_q      <= sticky_d;
            irq_q         <= irq_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            first_over_q  <= first_over_d;
        end
    end

    assign fault_sticky = sticky_q;
    assign irq          = irq_q;
    assign first_valid  = first_valid_q;
    assign first_ch     = first_ch_q;
    assign first_over   = first_over_q;

endmodule : voltage_monitor

// File: doc/voltage_monitor.md
VOLTAGE_MONITOR -- requirements
Module: voltage_monitor

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of monitored channels (1..16).
REQ-002 The block SHALL have parameter ADC_W, default 12, meaning the sample width in bits.
REQ-003 The block SHALL have parameter V_MIN, default 1000, meaning the lower fault threshold.
REQ-004 The block SHALL have parameter V_MAX, default 3000, meaning the upper fault threshold.
REQ-005 The block SHALL have parameter HYST, default 100, meaning the recovery hysteresis margin.
REQ-006 The block SHALL have parameter PERSIST, default 3, meaning the consecutive samples needed to enter or leave fault (>=1).
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port sample_valid, input, 1 bit: sample strobe.
REQ-010 The block SHALL have port sample_ch, input, $clog2(N_CH) bits (minimum 1): channel index of the sample.
REQ-011 The block SHALL have port sample_data, input, ADC_W bits: unsigned sample value.
REQ-012 The block SHALL have port clr_mask, input, N_CH bits: per-channel sticky-clear pulse.
REQ-013 The block SHALL have port fault_vec, output, N_CH bits: live per-channel fault (FAULT or RECOVER state).
REQ-014 The block SHALL have port fault_sticky, output, N_CH bits: latched per-channel fault.
REQ-015 The block SHALL have port fault_any, output, 1 bit: OR of fault_vec.
REQ-016 The block SHALL have port irq, output, 1 bit: one-cycle pulse on any new fault entry.
REQ-017 The block SHALL have ports first_valid (1 bit), first_ch ($clog2(N_CH) bits) and first_over (1 bit, 1 = over-voltage, 0 = under-voltage), all outputs forming the first-fault record.

Function
REQ-018 A sample SHALL be "out" if sample_data < V_MIN or > V_MAX, and "good" if V_MIN+HYST <= sample_data <= V_MAX-HYST; all comparisons SHALL be unsigned at ADC_W bits.
REQ-019 Only a channel addressed by a sample_valid cycle SHALL advance; a sample_ch >= N_CH SHALL be ignored.
REQ-020 Each channel FSM SHALL have the states OK, PEND, FAULT and RECOVER, with a per-channel counter of $clog2(PERSIST+1) bits.
REQ-021 In OK, an out sample SHALL set count to 1 and go to PEND, or go directly to FAULT if PERSIST=1.
REQ-022 In PEND, an out sample SHALL increment count and go to FAULT when count reaches PERSIST; any non-out sample SHALL clear count and return to OK.
REQ-023 In FAULT, a good sample SHALL set count to 1 and go to RECOVER, or go directly to OK if PERSIST=1; a non-good sample SHALL stay in FAULT.
REQ-024 In RECOVER, a good sample SHALL increment count and go to OK when count reaches PERSIST; any non-good sample SHALL return to FAULT without a new irq.
REQ-025 fault_vec, fault_sticky, irq and the first-fault record SHALL be registered and SHALL update on the clock edge that samples the qualifying input (visible the next cycle).
REQ-026 Entry into FAULT from PEND or OK SHALL record the type: over if the triggering sample > V_MAX, else under.
REQ-027 Entry into FAULT from PEND or OK SHALL set fault_sticky[ch] and pulse irq.
REQ-028 clr_mask[ch] SHALL clear fault_sticky[ch]; if a set and a clear of the same bit coincide, set SHALL win.
REQ-029 When first_valid=0, the first fault entry SHALL load first_ch/first_over and set first_valid=1, and later entries SHALL not overwrite it.
REQ-030 first_valid SHALL be cleared when clr_mask[first_ch] is asserted and no same-cycle fault entry on first_ch occurs.
REQ-031 fault_any SHALL equal the OR of the registered fault_vec, with no added latency.

Reset
REQ-032 On reset_n=0, all FSMs SHALL go to OK, all counters SHALL go to 0, and fault_vec, fault_sticky, fault_any, irq, first_valid, first_ch and first_over SHALL go to 0, asynchronously.
REQ-033 Reset asserted mid-PEND or mid-RECOVER SHALL discard partial counts, and the first post-reset sample SHALL be evaluated from OK.

Structure
REQ-034 Package voltage_monitor_pkg SHALL hold the channel state enum (OK, PEND, FAULT, RECOVER) and the fault-type enum (UNDER, OVER).
REQ-035 Sub-module vm_channel SHALL hold one channel's FSM, counter and entry/type outputs, and SHALL be instantiated N_CH times.
REQ-036 Sticky bits, irq and first-fault capture SHALL reside in the top level.

Verification (N_CH=4, V_MIN=1000, V_MAX=3000, HYST=100, PERSIST=3)
REQ-037 A bench SHALL check: ch2 gets samples 900, 900, 900 -> fault_vec[2]=1, irq pulses once, first_ch=2, first_over=0, the cycle after the third sample.
REQ-038 A bench SHALL check: ch1 gets 3100, 3100, 2000 -> no fault, and ch1 returns to OK with count 0.
REQ-039 A bench SHALL check: ch0 in FAULT gets 1050 x5 -> stays FAULT (inside the hysteresis band); then 1200 x3 -> fault_vec[0]=0 while fault_sticky[0] stays 1.
REQ-040 A bench SHALL check: ch3 in RECOVER after 1200, 1200 then gets 950 -> back to FAULT with no irq; a subsequent fault on ch1 leaves first_ch unchanged.
REQ-041 A bench SHALL check: clr_mask[2] in the same cycle as ch2's third out sample -> fault_sticky[2]=1 (set wins).
REQ-042 A bench SHALL check: reset_n pulsed low after two out samples on ch0, then 900 x2 -> no fault; a third 900 -> fault.
